// File: rtl/pulse_train_generator.sv
// pulse_train_generator
//   Transmit side of the event-counting link. Emits a burst of fixed-width
//   pulses once per period of PeriodCounterLimit+1 clocks, as a signed
//   16-bit DAC-style level on DataOutA with its level-inverse on DataOutB.
//   Burst shape (width, gap, pulse count) is captured at each period start,
//   so a mid-period change only takes effect from the next period.
//
// Ports
//   Clk                 in   system clock, rising edge
//   Reset               in   asynchronous active-low reset
//   Enable              in   1 = run, 0 = return to idle on the next edge
//   PeriodCounterLimit  in   period length minus 1 (clocks)
//   PulseWidth          in   high time per pulse; 0 = no pulses
//   PulseGap            in   low time between pulses; 0 behaves as 1
//   PulsesPerPeriod     in   pulses per burst; 0 = no pulses
//   HighLevel           in   output level while a pulse is high
//   LowLevel            in   output level otherwise
//   DataOutA            out  HighLevel during a pulse, else LowLevel
//   DataOutB            out  LowLevel during a pulse, else HighLevel
//   PeriodStrobe        out  1 for the first clock of every period
//   LastPeriodCount     out  pulses started in the previous completed period
module pulse_train_generator #(
  parameter int PERIOD_W = 32,
  parameter int CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic [PERIOD_W-1:0] PeriodCounterLimit,
  input  logic [CNT_W-1:0]    PulseWidth,
  input  logic [CNT_W-1:0]    PulseGap,
  input  logic [CNT_W-1:0]    PulsesPerPeriod,
  input  logic signed [15:0]  HighLevel,
  input  logic signed [15:0]  LowLevel,
  output logic signed [15:0]  DataOutA,
  output logic signed [15:0]  DataOutB,
  output logic                PeriodStrobe,
  output logic [CNT_W-1:0]    LastPeriodCount
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    PULSE_HI    = 2'd1,
    PULSE_GAP   = 2'd2,
    WAIT_PERIOD = 2'd3
  } state_t;

  state_t              state, state_next;
  logic [PERIOD_W-1:0] period_counter, period_counter_next;
  logic [CNT_W-1:0]    hold_counter, hold_counter_next;
  logic [CNT_W-1:0]    sent_count, sent_count_next;
  logic [CNT_W-1:0]    width_shadow, width_shadow_next;
  logic [CNT_W-1:0]    gap_shadow, gap_shadow_next;
  logic [CNT_W-1:0]    count_shadow, count_shadow_next;
  logic [CNT_W-1:0]    last_count_next;
  logic                strobe_next;
  logic                period_start;

  // State and counter registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state           <= IDLE;
      period_counter  <= '0;
      hold_counter    <= '0;
      sent_count      <= '0;
      width_shadow    <= '0;
      gap_shadow      <= '0;
      count_shadow    <= '0;
      LastPeriodCount <= '0;
      PeriodStrobe    <= 1'b0;
    end else begin
      state           <= state_next;
      period_counter  <= period_counter_next;
      hold_counter    <= hold_counter_next;
      sent_count      <= sent_count_next;
      width_shadow    <= width_shadow_next;
      gap_shadow      <= gap_shadow_next;
      count_shadow    <= count_shadow_next;
      LastPeriodCount <= last_count_next;
      PeriodStrobe    <= strobe_next;
    end
  end

  // Next-state logic. Priority: Enable low, then period start (which
  // truncates any pulse or gap in progress), then the burst sequencing.
  always_comb begin
    state_next          = state;
    period_counter_next = period_counter;
    hold_counter_next   = hold_counter;
    sent_count_next     = sent_count;
    width_shadow_next   = width_shadow;
    gap_shadow_next     = gap_shadow;
    count_shadow_next   = count_shadow;
    last_count_next     = LastPeriodCount;
    strobe_next         = 1'b0;

    period_start = Enable &&
                   ((state == IDLE) || (period_counter == PeriodCounterLimit));

    if (!Enable) begin
      state_next          = IDLE;
      period_counter_next = '0;
      hold_counter_next   = '0;
      sent_count_next     = '0;
    end else if (period_start) begin
      period_counter_next = '0;
      width_shadow_next   = PulseWidth;
      gap_shadow_next     = (PulseGap == '0) ? CNT_W'(1) : PulseGap;
      count_shadow_next   = PulsesPerPeriod;
      strobe_next         = 1'b1;
      // Leaving IDLE is not the end of a period, so there is nothing to report.
      if (state != IDLE) begin
        last_count_next = sent_count;
      end
      if ((PulseWidth != '0) && (PulsesPerPeriod != '0)) begin
        state_next        = PULSE_HI;
        hold_counter_next = PulseWidth - CNT_W'(1);
        sent_count_next   = CNT_W'(1);
      end else begin
        state_next        = WAIT_PERIOD;
        hold_counter_next = '0;
        sent_count_next   = '0;
      end
    end else begin
      period_counter_next = period_counter + PERIOD_W'(1);
      case (state)
        PULSE_HI: begin
          if (hold_counter == '0) begin
            if (sent_count < count_shadow) begin
              state_next        = PULSE_GAP;
              hold_counter_next = gap_shadow - CNT_W'(1);
            end else begin
              state_next = WAIT_PERIOD;
            end
          end else begin
            hold_counter_next = hold_counter - CNT_W'(1);
          end
        end
        PULSE_GAP: begin
          if (hold_counter == '0) begin
            state_next        = PULSE_HI;
            hold_counter_next = width_shadow - CNT_W'(1);
            // Count saturates rather than wrapping on very long bursts.
            if (sent_count != '1) begin
              sent_count_next = sent_count + CNT_W'(1);
            end
          end else begin
            hold_counter_next = hold_counter - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs follow registered state; only the level values pass straight through.
  always_comb begin
    DataOutA = LowLevel;
    DataOutB = HighLevel;
    if (state == PULSE_HI) begin
      DataOutA = HighLevel;
      DataOutB = LowLevel;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// tb_pulse_train_generator
//   Directed bench for pulse_train_generator. Each test task configures a
//   burst, records the outputs clock by clock from the first clock of the
//   period onward, and compares selected clocks against hand-derived values.
module tb_pulse_train_generator;

  localparam int TRACE_LEN = 6400;

  logic               Clk;
  logic               Reset;
  logic               Enable;
  logic [31:0]        PeriodCounterLimit;
  logic [15:0]        PulseWidth;
  logic [15:0]        PulseGap;
  logic [15:0]        PulsesPerPeriod;
  logic signed [15:0] HighLevel;
  logic signed [15:0] LowLevel;
  logic signed [15:0] DataOutA;
  logic signed [15:0] DataOutB;
  logic               PeriodStrobe;
  logic [15:0]        LastPeriodCount;

  int passed;
  int total;

  logic [15:0] a_tr [0:TRACE_LEN-1];
  logic [15:0] b_tr [0:TRACE_LEN-1];
  logic        s_tr [0:TRACE_LEN-1];
  logic [15:0] l_tr [0:TRACE_LEN-1];

  pulse_train_generator #(.PERIOD_W(32), .CNT_W(16)) dut (
    .Clk               (Clk),
    .Reset             (Reset),
    .Enable            (Enable),
    .PeriodCounterLimit(PeriodCounterLimit),
    .PulseWidth        (PulseWidth),
    .PulseGap          (PulseGap),
    .PulsesPerPeriod   (PulsesPerPeriod),
    .HighLevel         (HighLevel),
    .LowLevel          (LowLevel),
    .DataOutA          (DataOutA),
    .DataOutB          (DataOutB),
    .PeriodStrobe      (PeriodStrobe),
    .LastPeriodCount   (LastPeriodCount)
  );

  // 10 ns clock; inputs change and outputs are sampled on the falling edge.
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Records n clocks of outputs starting at trace index base.
  task automatic capture(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      a_tr[base+i] = DataOutA;
      b_tr[base+i] = DataOutB;
      s_tr[base+i] = PeriodStrobe;
      l_tr[base+i] = LastPeriodCount;
    end
  endtask

  // Returns to idle, loads a burst configuration and enables; the next
  // captured clock is clock 0 of the first period.
  task automatic start_run(input int limit, input int w, input int g, input int n);
    Enable = 1'b0;
    @(negedge Clk);
    PeriodCounterLimit = 32'(limit);
    PulseWidth         = 16'(w);
    PulseGap           = 16'(g);
    PulsesPerPeriod    = 16'(n);
    Enable             = 1'b1;
  endtask

  function automatic int count_high(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (a_tr[i] == 16'h7fff) c++;
    return c;
  endfunction

  function automatic int count_rises(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++)
      if (a_tr[i] == 16'h7fff && (i == lo || a_tr[i-1] != 16'h7fff)) c++;
    return c;
  endfunction

  function automatic int count_strobes(input int lo, input int hi);
    int c = 0;
    for (int i = lo; i <= hi; i++) if (s_tr[i]) c++;
    return c;
  endfunction

  task automatic test_reset();
    Reset = 1'b0;
    Enable = 1'b0;
    HighLevel = 16'sh7fff;
    LowLevel = 16'sh0000;
    repeat (3) @(negedge Clk);
    total++; if (DataOutA !== 16'h0000) $display("[TB] FAIL reset_a got %h want 0000", DataOutA); else passed++;
    total++; if (DataOutB !== 16'h7fff) $display("[TB] FAIL reset_b got %h want 7fff", DataOutB); else passed++;
    total++; if (PeriodStrobe !== 1'b0) $display("[TB] FAIL reset_strobe got %b want 0", PeriodStrobe); else passed++;
    total++; if (LastPeriodCount !== 16'd0) $display("[TB] FAIL reset_last got %0d want 0", LastPeriodCount); else passed++;
    HighLevel = 16'sh1234;
    LowLevel = -16'sh0100;
    #1;
    total++; if (DataOutA !== 16'hff00) $display("[TB] FAIL reset_level_a got %h want ff00", DataOutA); else passed++;
    total++; if (DataOutB !== 16'h1234) $display("[TB] FAIL reset_level_b got %h want 1234", DataOutB); else passed++;
    HighLevel = 16'sh7fff;
    LowLevel = 16'sh0000;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_long_burst();
    int v;
    start_run(3124, 20, 20, 25);
    capture(0, 6251);
    v = count_rises(0, 3124);
    total++; if (v !== 25) $display("[TB] FAIL long_pulses got %0d want 25", v); else passed++;
    v = count_high(0, 3124);
    total++; if (v !== 500) $display("[TB] FAIL long_high_clks got %0d want 500", v); else passed++;
    total++; if (a_tr[0] !== 16'h7fff) $display("[TB] FAIL long_first got %h want 7fff", a_tr[0]); else passed++;
    total++; if (b_tr[0] !== 16'h0000) $display("[TB] FAIL long_first_b got %h want 0000", b_tr[0]); else passed++;
    total++; if (a_tr[20] !== 16'h0000) $display("[TB] FAIL long_gap got %h want 0000", a_tr[20]); else passed++;
    total++; if (a_tr[40] !== 16'h7fff) $display("[TB] FAIL long_second got %h want 7fff", a_tr[40]); else passed++;
    total++; if (a_tr[979] !== 16'h7fff) $display("[TB] FAIL long_last_hi got %h want 7fff", a_tr[979]); else passed++;
    v = count_high(980, 3124);
    total++; if (v !== 0) $display("[TB] FAIL long_tail_low got %0d high clks want 0", v); else passed++;
    total++; if (b_tr[980] !== 16'h7fff) $display("[TB] FAIL long_tail_b got %h want 7fff", b_tr[980]); else passed++;
    v = count_strobes(0, 6250);
    total++; if (v !== 3) $display("[TB] FAIL long_strobes got %0d want 3", v); else passed++;
    total++; if (s_tr[3125] !== 1'b1) $display("[TB] FAIL long_strobe_3125 got %b want 1", s_tr[3125]); else passed++;
    total++; if (l_tr[3124] !== 16'd0) $display("[TB] FAIL long_last_before got %0d want 0", l_tr[3124]); else passed++;
    total++; if (l_tr[3125] !== 16'd25) $display("[TB] FAIL long_last_after got %0d want 25", l_tr[3125]); else passed++;
    total++; if (a_tr[3125] !== 16'h7fff) $display("[TB] FAIL long_restart got %h want 7fff", a_tr[3125]); else passed++;
  endtask

  task automatic test_truncation();
    int v;
    start_run(99, 30, 10, 5);
    capture(0, 101);
    total++; if (a_tr[29] !== 16'h7fff) $display("[TB] FAIL trunc_p1_end got %h want 7fff", a_tr[29]); else passed++;
    total++; if (a_tr[30] !== 16'h0000) $display("[TB] FAIL trunc_gap1 got %h want 0000", a_tr[30]); else passed++;
    total++; if (a_tr[39] !== 16'h0000) $display("[TB] FAIL trunc_gap1_end got %h want 0000", a_tr[39]); else passed++;
    total++; if (a_tr[40] !== 16'h7fff) $display("[TB] FAIL trunc_p2 got %h want 7fff", a_tr[40]); else passed++;
    total++; if (a_tr[70] !== 16'h0000) $display("[TB] FAIL trunc_gap2 got %h want 0000", a_tr[70]); else passed++;
    total++; if (a_tr[99] !== 16'h7fff) $display("[TB] FAIL trunc_p3_end got %h want 7fff", a_tr[99]); else passed++;
    v = count_high(0, 99);
    total++; if (v !== 80) $display("[TB] FAIL trunc_high_clks got %0d want 80", v); else passed++;
    v = count_rises(0, 99);
    total++; if (v !== 3) $display("[TB] FAIL trunc_pulses got %0d want 3", v); else passed++;
    total++; if (s_tr[99] !== 1'b0) $display("[TB] FAIL trunc_strobe_99 got %b want 0", s_tr[99]); else passed++;
    total++; if (s_tr[100] !== 1'b1) $display("[TB] FAIL trunc_strobe_100 got %b want 1", s_tr[100]); else passed++;
    total++; if (a_tr[100] !== 16'h7fff) $display("[TB] FAIL trunc_restart got %h want 7fff", a_tr[100]); else passed++;
    total++; if (l_tr[100] !== 16'd3) $display("[TB] FAIL trunc_last got %0d want 3", l_tr[100]); else passed++;
  endtask

  task automatic test_zero_cases();
    int v;
    start_run(49, 0, 5, 5);
    capture(0, 51);
    v = count_high(0, 50);
    total++; if (v !== 0) $display("[TB] FAIL zero_w_high got %0d want 0", v); else passed++;
    total++; if (s_tr[0] !== 1'b1) $display("[TB] FAIL zero_w_strobe0 got %b want 1", s_tr[0]); else passed++;
    total++; if (s_tr[1] !== 1'b0) $display("[TB] FAIL zero_w_strobe1 got %b want 0", s_tr[1]); else passed++;
    total++; if (s_tr[50] !== 1'b1) $display("[TB] FAIL zero_w_strobe50 got %b want 1", s_tr[50]); else passed++;
    total++; if (l_tr[49] !== 16'd3) $display("[TB] FAIL zero_w_last_hold got %0d want 3", l_tr[49]); else passed++;
    total++; if (l_tr[50] !== 16'd0) $display("[TB] FAIL zero_w_last got %0d want 0", l_tr[50]); else passed++;
    start_run(49, 5, 5, 0);
    capture(0, 51);
    v = count_high(0, 50);
    total++; if (v !== 0) $display("[TB] FAIL zero_n_high got %0d want 0", v); else passed++;
    total++; if (s_tr[50] !== 1'b1) $display("[TB] FAIL zero_n_strobe50 got %b want 1", s_tr[50]); else passed++;
    total++; if (l_tr[50] !== 16'd0) $display("[TB] FAIL zero_n_last got %0d want 0", l_tr[50]); else passed++;
  endtask

  task automatic test_gap_zero();
    int v;
    start_run(49, 3, 0, 3);
    capture(0, 51);
    total++; if (a_tr[2] !== 16'h7fff) $display("[TB] FAIL gap0_p1 got %h want 7fff", a_tr[2]); else passed++;
    total++; if (a_tr[3] !== 16'h0000) $display("[TB] FAIL gap0_gap1 got %h want 0000", a_tr[3]); else passed++;
    total++; if (a_tr[4] !== 16'h7fff) $display("[TB] FAIL gap0_p2 got %h want 7fff", a_tr[4]); else passed++;
    total++; if (a_tr[7] !== 16'h0000) $display("[TB] FAIL gap0_gap2 got %h want 0000", a_tr[7]); else passed++;
    total++; if (a_tr[10] !== 16'h7fff) $display("[TB] FAIL gap0_p3_end got %h want 7fff", a_tr[10]); else passed++;
    total++; if (a_tr[11] !== 16'h0000) $display("[TB] FAIL gap0_wait got %h want 0000", a_tr[11]); else passed++;
    v = count_high(0, 49);
    total++; if (v !== 9) $display("[TB] FAIL gap0_high_clks got %0d want 9", v); else passed++;
    total++; if (l_tr[50] !== 16'd3) $display("[TB] FAIL gap0_last got %0d want 3", l_tr[50]); else passed++;
  endtask

  task automatic test_midperiod_change();
    int v;
    start_run(99, 20, 10, 3);
    capture(0, 11);
    PulseWidth = 16'd8;
    capture(11, 130);
    total++; if (a_tr[19] !== 16'h7fff) $display("[TB] FAIL mid_keep_w got %h want 7fff", a_tr[19]); else passed++;
    total++; if (a_tr[20] !== 16'h0000) $display("[TB] FAIL mid_gap got %h want 0000", a_tr[20]); else passed++;
    total++; if (a_tr[49] !== 16'h7fff) $display("[TB] FAIL mid_p2_end got %h want 7fff", a_tr[49]); else passed++;
    total++; if (a_tr[107] !== 16'h7fff) $display("[TB] FAIL mid_new_end got %h want 7fff", a_tr[107]); else passed++;
    total++; if (a_tr[108] !== 16'h0000) $display("[TB] FAIL mid_new_gap got %h want 0000", a_tr[108]); else passed++;
    total++; if (a_tr[118] !== 16'h7fff) $display("[TB] FAIL mid_new_p2 got %h want 7fff", a_tr[118]); else passed++;
    total++; if (a_tr[126] !== 16'h0000) $display("[TB] FAIL mid_new_p2_end got %h want 0000", a_tr[126]); else passed++;
    v = count_high(100, 140);
    total++; if (v !== 21) $display("[TB] FAIL mid_new_high got %0d want 21", v); else passed++;
  endtask

  task automatic test_one_clk_period();
    int v;
    start_run(0, 5, 10, 2);
    capture(0, 4);
    v = count_high(0, 3);
    total++; if (v !== 4) $display("[TB] FAIL one_clk_high got %0d want 4", v); else passed++;
    v = count_strobes(0, 3);
    total++; if (v !== 4) $display("[TB] FAIL one_clk_strobes got %0d want 4", v); else passed++;
    total++; if (l_tr[0] !== 16'd3) $display("[TB] FAIL one_clk_last0 got %0d want 3", l_tr[0]); else passed++;
    total++; if (l_tr[1] !== 16'd1) $display("[TB] FAIL one_clk_last1 got %0d want 1", l_tr[1]); else passed++;
  endtask

  task automatic test_levels();
    HighLevel = 16'sh1234;
    LowLevel = -16'sh0100;
    start_run(9, 2, 1, 1);
    capture(0, 3);
    total++; if (a_tr[0] !== 16'h1234) $display("[TB] FAIL levels_a_hi got %h want 1234", a_tr[0]); else passed++;
    total++; if (b_tr[0] !== 16'hff00) $display("[TB] FAIL levels_b_hi got %h want ff00", b_tr[0]); else passed++;
    total++; if (a_tr[2] !== 16'hff00) $display("[TB] FAIL levels_a_lo got %h want ff00", a_tr[2]); else passed++;
    total++; if (b_tr[2] !== 16'h1234) $display("[TB] FAIL levels_b_lo got %h want 1234", b_tr[2]); else passed++;
    HighLevel = 16'sh7fff;
    LowLevel = 16'sh0000;
  endtask

  task automatic test_enable_drop();
    // Pulse width exceeds the 20-clk period, so the first period reports 1.
    start_run(19, 20, 10, 3);
    capture(0, 25);
    total++; if (a_tr[24] !== 16'h7fff) $display("[TB] FAIL en_in_pulse got %h want 7fff", a_tr[24]); else passed++;
    Enable = 1'b0;
    @(negedge Clk);
    total++; if (DataOutA !== 16'h0000) $display("[TB] FAIL en_drop_a got %h want 0000", DataOutA); else passed++;
    total++; if (PeriodStrobe !== 1'b0) $display("[TB] FAIL en_drop_strobe got %b want 0", PeriodStrobe); else passed++;
    total++; if (LastPeriodCount !== 16'd1) $display("[TB] FAIL en_drop_last got %0d want 1", LastPeriodCount); else passed++;
    @(negedge Clk);
    Enable = 1'b1;
    @(negedge Clk);
    total++; if (PeriodStrobe !== 1'b1) $display("[TB] FAIL en_restart_strobe got %b want 1", PeriodStrobe); else passed++;
    total++; if (DataOutA !== 16'h7fff) $display("[TB] FAIL en_restart_a got %h want 7fff", DataOutA); else passed++;
  endtask

  task automatic test_reset_mid_pulse();
    repeat (3) @(negedge Clk);
    total++; if (DataOutA !== 16'h7fff) $display("[TB] FAIL rst_pre_a got %h want 7fff", DataOutA); else passed++;
    #2;
    Reset = 1'b0;
    #1;
    total++; if (DataOutA !== 16'h0000) $display("[TB] FAIL rst_async_a got %h want 0000", DataOutA); else passed++;
    total++; if (DataOutB !== 16'h7fff) $display("[TB] FAIL rst_async_b got %h want 7fff", DataOutB); else passed++;
    total++; if (LastPeriodCount !== 16'd0) $display("[TB] FAIL rst_async_last got %0d want 0", LastPeriodCount); else passed++;
    Enable = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
  endtask

  initial begin
    passed = 0;
    total = 0;
    Reset = 1'b0;
    Enable = 1'b0;
    PeriodCounterLimit = 32'd0;
    PulseWidth = 16'd0;
    PulseGap = 16'd0;
    PulsesPerPeriod = 16'd0;
    HighLevel = 16'sh7fff;
    LowLevel = 16'sh0000;
    test_reset();
    test_long_burst();
    test_truncation();
    test_zero_cases();
    test_gap_zero();
    test_midperiod_change();
    test_one_clk_period();
    test_levels();
    test_enable_drop();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
